// File: rtl/lsu_pkg.sv
// Shared state, error and size encodings for the APB load/store unit,
// plus the alignment rule used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_SLVERR  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // A dword request is only legal on a 64-bit bus.
  function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size,
                                         input logic dw64);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = low[0];
      SZ_W:    bad = |low[1:0];
      SZ_D:    bad = (|low) | ~dw64;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: write strobes and data shift for stores, read shift
// plus sign/zero extension for loads, all sized from DATA_WIDTH.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]      off,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_W-1:0]     pstrb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [7:0]            byte_mask_s;
  logic [DATA_WIDTH-1:0] keep_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic                  sign_s;

  // Lane steering and load extension; keep_s marks the bits the access owns.
  always_comb begin
    byte_mask_s = 8'h00;
    keep_s      = '0;
    sign_s      = 1'b0;
    shifted_s   = prdata >> {off, 3'b000};
    case (size)
      SZ_B: begin
        byte_mask_s = 8'h01;
        keep_s      = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        sign_s      = shifted_s[7];
      end
      SZ_H: begin
        byte_mask_s = 8'h03;
        keep_s      = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        sign_s      = shifted_s[15];
      end
      SZ_W: begin
        byte_mask_s = 8'h0F;
        keep_s      = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        sign_s      = shifted_s[31];
      end
      SZ_D: begin
        byte_mask_s = 8'hFF;
        keep_s      = '1;
        sign_s      = 1'b0;
      end
      default: begin
        byte_mask_s = 8'h00;
        keep_s      = '0;
        sign_s      = 1'b0;
      end
    endcase
    pstrb  = STRB_W'(byte_mask_s) << off;
    pwdata = wdata << {off, 3'b000};
    // A full-width access has keep_s all ones, so it passes unextended.
    rdata  = (shifted_s & keep_s) | ({DATA_WIDTH{sign_s & ~is_unsigned}} & ~keep_s);
  end

endmodule

// File: rtl/apb_lsu.sv
// APB4 master that runs one fetch/load/store per request, with lane
// steering, load extension, alignment checking and an ACCESS timeout.
module apb_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rts_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH-1:0]   APB_pwdata,
  output logic [DATA_WIDTH/8-1:0] APB_pstrb,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  input  logic                    APB_pready,
  input  logic                    APB_pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic IS_DW64 = (DATA_WIDTH == 64) ? 1'b1 : 1'b0;
  localparam logic TO_EN   = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;

  logic [OFF_W-1:0]      lane_off_s;
  logic [1:0]            lane_size_s;
  logic [DATA_WIDTH-1:0] lane_pwdata_s;
  logic [STRB_W-1:0]     lane_pstrb_s;
  logic [DATA_WIDTH-1:0] lane_rdata_s;

  // In IDLE the lane sees the incoming request; afterwards the captured one.
  assign lane_off_s  = (state_q == IDLE) ? req_addr[OFF_W-1:0] : off_q;
  assign lane_size_s = (state_q == IDLE) ? req_size : size_q;

  lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .off         (lane_off_s),
    .size        (lane_size_s),
    .is_unsigned (uns_q),
    .wdata       (req_wdata),
    .prdata      (APB_prdata),
    .pwdata      (lane_pwdata_s),
    .pstrb       (lane_pstrb_s),
    .rdata       (lane_rdata_s)
  );

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          off_d       = req_addr[OFF_W-1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          if (is_misaligned(req_addr[2:0], req_size, IS_DW64)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ALIGN;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            pwdata_d  = req_write ? lane_pwdata_s : '0;
            pstrb_d   = req_write ? lane_pstrb_s : '0;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (APB_pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          if (APB_pslverr) begin
            rsp_err_d   = ERR_SLVERR;
            rsp_rdata_d = '0;
          end else begin
            rsp_err_d   = ERR_OK;
            rsp_rdata_d = pwrite_q ? '0 : lane_rdata_s;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // req_ready stays low here, so no accept can coincide with the consume.
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rts_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_rdata_q <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign APB_psel    = psel_q;
  assign APB_penable = penable_q;
  assign APB_pwrite  = pwrite_q;
  assign APB_paddr   = paddr_q;
  assign APB_pwdata  = pwdata_q;
  assign APB_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_lsu.sv
// Scoreboard bench for apb_lsu: a 32-bit unit with a short timeout behind a
// programmable APB slave, and a 64-bit unit behind an always-ready slave.
`timescale 1ns/1ps
module tb_apb_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rts_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] apb_paddr, apb_pwdata;
  logic [31:0] apb_prdata = 32'h0;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic        apb_pready = 1'b0, apb_pslverr = 1'b0;
  logic [3:0]  apb_pstrb;

  logic        w_req_valid, w_req_ready, w_req_write, w_req_unsigned;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata, w_rsp_rdata, w_pwdata, w_prdata;
  logic [1:0]  w_req_size, w_rsp_err;
  logic        w_rsp_valid, w_rsp_ready;
  logic [31:0] w_paddr;
  logic        w_psel, w_penable, w_pwrite, w_pready, w_pslverr;
  logic [7:0]  w_pstrb;

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk(clk), .rts_n(rts_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .APB_paddr(apb_paddr), .APB_psel(apb_psel), .APB_penable(apb_penable),
    .APB_pwrite(apb_pwrite), .APB_pwdata(apb_pwdata), .APB_pstrb(apb_pstrb),
    .APB_prdata(apb_prdata), .APB_pready(apb_pready), .APB_pslverr(apb_pslverr));

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut64 (
    .clk(clk), .rts_n(rts_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_write(w_req_write), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .req_size(w_req_size), .req_unsigned(w_req_unsigned), .rsp_valid(w_rsp_valid),
    .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err),
    .APB_paddr(w_paddr), .APB_psel(w_psel), .APB_penable(w_penable),
    .APB_pwrite(w_pwrite), .APB_pwdata(w_pwdata), .APB_pstrb(w_pstrb),
    .APB_prdata(w_prdata), .APB_pready(w_pready), .APB_pslverr(w_pslverr));

  // Slave for the 32-bit unit: slv_waits wait states, then pready (unless hung).
  int          slv_waits = 0;
  int          wait_cnt  = 0;
  logic        slv_err   = 1'b0;
  logic        slv_hang  = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  always @(negedge clk) begin
    if (apb_psel && apb_penable && !slv_hang && wait_cnt >= slv_waits) begin
      apb_pready = 1'b1; apb_pslverr = slv_err; apb_prdata = slv_rdata;
    end else begin
      apb_pready = 1'b0; apb_pslverr = 1'b1; apb_prdata = 32'hDEAD_0000;
      if (apb_psel && apb_penable) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  typedef struct { logic [63:0] rdata; logic [1:0] err; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic push_exp(input logic [63:0] rd, input logic [1:0] er);
    exp_t e;
    e.rdata = rd; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e.rdata = 64'hBAD0_BAD0_BAD0_BAD0; e.err = 2'b00; end
  endtask

  // Drive one request to the 32-bit unit; returns just after the accept edge.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] er, input logic [1:0] ee);
    push_exp({32'h0, er}, ee);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output logic ok);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 40) begin
      if (rsp_valid === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if ({req_ready, rsp_valid, rsp_err} !== 4'b1000) $display("FAIL rst_ctl got %b want 1000", {req_ready, rsp_valid, rsp_err}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if ({apb_psel, apb_penable, apb_pwrite} !== 3'b000) $display("FAIL rst_apb_ctl got %b want 000", {apb_psel, apb_penable, apb_pwrite}); else n_pass++;
    n_checks++; if ({apb_paddr, apb_pwdata, apb_pstrb} !== 68'h0) $display("FAIL rst_apb_data got %h want 0", {apb_paddr, apb_pwdata, apb_pstrb}); else n_pass++;
  endtask

  task automatic test_store_word();
    int cyc; logic ok; exp_t e;
    send(1'b1, 32'h104, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 2'b00);
    n_checks++; if ({apb_psel, apb_penable, apb_pwrite} !== 3'b101) $display("FAIL st_setup got %b want 101", {apb_psel, apb_penable, apb_pwrite}); else n_pass++;
    n_checks++; if (apb_paddr !== 32'h104) $display("FAIL st_paddr got %h want 104", apb_paddr); else n_pass++;
    n_checks++; if (apb_pstrb !== 4'hF) $display("FAIL st_pstrb got %h want f", apb_pstrb); else n_pass++;
    n_checks++; if (apb_pwdata !== 32'hDEADBEEF) $display("FAIL st_pwdata got %h want deadbeef", apb_pwdata); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({apb_psel, apb_penable, rsp_valid} !== 3'b110) $display("FAIL st_access got %b want 110", {apb_psel, apb_penable, rsp_valid}); else n_pass++;
    wait_rsp(cyc, ok);
    n_checks++; if (!ok || cyc != 1) $display("FAIL st_latency got ok=%0b cyc=%0d want ok=1 cyc=1", ok, cyc); else n_pass++;
    pop_exp(e);
    n_checks++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL st_rsp got %b/%h want %b/%h", rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
    n_checks++; if ({apb_psel, apb_penable} !== 2'b00) $display("FAIL st_release got %b want 00", {apb_psel, apb_penable}); else n_pass++;
    ack();
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL st_ack got %b want 01", {rsp_valid, req_ready}); else n_pass++;
  endtask

  task automatic test_load_ext();
    int cyc; logic ok; exp_t e;
    logic [31:0] ad [5]; logic [1:0] sz [5]; logic un [5]; logic [31:0] ex [5];
    ad = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
    sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    un = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h80112233};
    slv_rdata = 32'h80112233;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, ad[i], 32'hFFFFFFFF, sz[i], un[i], ex[i], 2'b00);
      n_checks++; if ({apb_pwrite, apb_pstrb} !== 5'b0) $display("FAIL ld_strb[%0d] got %b want 00000", i, {apb_pwrite, apb_pstrb}); else n_pass++;
      n_checks++; if (apb_paddr !== (ad[i] & 32'hFFFFFFFC)) $display("FAIL ld_paddr[%0d] got %h want %h", i, apb_paddr, ad[i] & 32'hFFFFFFFC); else n_pass++;
      wait_rsp(cyc, ok);
      pop_exp(e);
      n_checks++; if (!ok || rsp_err !== e.err || rsp_rdata !== e.rdata[31:0]) $display("FAIL ld_rdata[%0d] got ok=%0b %b/%h want %b/%h", i, ok, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
      ack();
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic ok; exp_t e;
    logic wr [3]; logic [31:0] ad [3]; logic [1:0] sz [3];
    wr = '{1'b1, 1'b0, 1'b0};
    ad = '{32'h301, 32'h300, 32'h102};
    sz = '{2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 3; i++) begin
      send(wr[i], ad[i], 32'h5555AAAA, sz[i], 1'b0, 32'h0, 2'b01);
      n_checks++; if (apb_psel !== 1'b0) $display("FAIL mis_psel[%0d] got %b want 0", i, apb_psel); else n_pass++;
      wait_rsp(cyc, ok);
      pop_exp(e);
      n_checks++; if (!ok || cyc != 0 || {rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL mis_rsp[%0d] got ok=%0b cyc=%0d %b/%h want cyc=0 %b/%h", i, ok, cyc, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
      ack();
    end
  endtask

  task automatic test_wait_slverr();
    int cyc, n_acc; logic ok, stable; exp_t e;
    logic [31:0] pw0, pa0;
    slv_waits = 3; slv_err = 1'b1; slv_rdata = 32'h55AA55AA;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) send(1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0, 32'h0, 2'b10);
      else        send(1'b0, 32'h404, 32'h0, 2'b10, 1'b0, 32'h0, 2'b10);
      pw0 = apb_pwdata; pa0 = apb_paddr;
      n_checks++; if (pa0 !== 32'h400 + 32'(4 * i)) $display("FAIL ws_paddr[%0d] got %h want %h", i, pa0, 32'h400 + 32'(4 * i)); else n_pass++;
      @(posedge clk); #1;
      n_acc = 0; stable = 1'b1;
      while (apb_psel && apb_penable && n_acc < 20) begin
        n_acc++;
        if (apb_paddr !== pa0 || apb_pwdata !== pw0) stable = 1'b0;
        @(posedge clk); #1;
      end
      n_checks++; if (n_acc != 4 || !stable) $display("FAIL ws_access[%0d] got cycles=%0d stable=%0b want 4/1", i, n_acc, stable); else n_pass++;
      wait_rsp(cyc, ok);
      pop_exp(e);
      n_checks++; if (!ok || cyc != 0 || {rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL ws_rsp[%0d] got ok=%0b %b/%h want %b/%h", i, ok, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
      ack();
    end
    slv_waits = 0; slv_err = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, n_acc; logic ok; exp_t e;
    slv_hang = 1'b1;
    send(1'b0, 32'h500, 32'h0, 2'b10, 1'b0, 32'h0, 2'b11);
    @(posedge clk); #1;
    n_acc = 0;
    while (apb_psel && apb_penable && n_acc < 20) begin
      n_acc++;
      @(posedge clk); #1;
    end
    n_checks++; if (n_acc != 4 || apb_psel !== 1'b0) $display("FAIL to_access got cycles=%0d psel=%b want 4/0", n_acc, apb_psel); else n_pass++;
    wait_rsp(cyc, ok);
    pop_exp(e);
    n_checks++; if (!ok || {rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL to_rsp got ok=%0b %b/%h want %b/%h", ok, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
    ack();
    slv_hang = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc; logic ok; exp_t e;
    slv_rdata = 32'hA5A50F0F;
    send(1'b0, 32'h600, 32'h0, 2'b10, 1'b0, 32'hA5A50F0F, 2'b00);
    wait_rsp(cyc, ok);
    pop_exp(e);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (!ok || {rsp_valid, req_ready, rsp_err, rsp_rdata} !== {2'b10, e.err, e.rdata[31:0]}) $display("FAIL bp_hold[%0d] got %b%b %b/%h want 10 %b/%h", i, rsp_valid, req_ready, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
      @(posedge clk); #1;
    end
    // A request presented while the response is consumed must wait a cycle.
    push_exp({32'h0, 32'hFFFF8011}, 2'b00);
    slv_rdata = 32'h80112233;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h606; req_size = 2'b01; req_unsigned = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if ({apb_psel, rsp_valid, req_ready} !== 3'b001) $display("FAIL bp_no_accept got %b want 001", {apb_psel, rsp_valid, req_ready}); else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if ({apb_psel, apb_penable, req_ready} !== 3'b100) $display("FAIL bp_accept got %b want 100", {apb_psel, apb_penable, req_ready}); else n_pass++;
    wait_rsp(cyc, ok);
    pop_exp(e);
    n_checks++; if (!ok || {rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL bp_rsp got ok=%0b %b/%h want %b/%h", ok, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid();
    int cyc; logic ok; exp_t e;
    slv_hang = 1'b1;
    send(1'b0, 32'h700, 32'h0, 2'b10, 1'b0, 32'h0, 2'b00);
    @(posedge clk); #1;
    n_checks++; if ({apb_psel, apb_penable} !== 2'b11) $display("FAIL rm_access got %b want 11", {apb_psel, apb_penable}); else n_pass++;
    rts_n = 1'b0;
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_checks++; if ({apb_psel, apb_penable, rsp_valid, req_ready} !== 4'b0001) $display("FAIL rm_abort got %b want 0001", {apb_psel, apb_penable, rsp_valid, req_ready}); else n_pass++;
    rts_n = 1'b1; slv_hang = 1'b0; slv_rdata = 32'h00001234;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rm_discard got %b want 0", rsp_valid); else n_pass++;
    send(1'b0, 32'h704, 32'h0, 2'b10, 1'b0, 32'h00001234, 2'b00);
    wait_rsp(cyc, ok);
    pop_exp(e);
    n_checks++; if (!ok || cyc != 2 || {rsp_err, rsp_rdata} !== {e.err, e.rdata[31:0]}) $display("FAIL rm_next got ok=%0b cyc=%0d %b/%h want cyc=2 %b/%h", ok, cyc, rsp_err, rsp_rdata, e.err, e.rdata[31:0]); else n_pass++;
    ack();
  endtask

  task automatic test_dw64();
    int cyc; exp_t e;
    logic wr [4]; logic [31:0] ad [4]; logic [63:0] wd [4]; logic [1:0] sz [4]; logic un [4];
    logic [7:0] xs [4]; logic [63:0] xw [4]; logic [63:0] xr [4];
    wr = '{1'b1, 1'b1, 1'b0, 1'b0};
    ad = '{32'h1008, 32'h1005, 32'h1004, 32'h1004};
    wd = '{64'h0123456789ABCDEF, 64'h00000000000000AB, 64'h0, 64'h0};
    sz = '{2'b11, 2'b00, 2'b10, 2'b10};
    un = '{1'b0, 1'b0, 1'b0, 1'b1};
    xs = '{8'hFF, 8'h20, 8'h00, 8'h00};
    xw = '{64'h0123456789ABCDEF, 64'h0000AB0000000000, 64'h0, 64'h0};
    xr = '{64'h0, 64'h0, 64'hFFFFFFFF87654321, 64'h0000000087654321};
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (w_req_ready !== 1'b1) $display("FAIL w_ready[%0d] got %b want 1", i, w_req_ready); else n_pass++;
      push_exp(xr[i], 2'b00);
      w_req_valid = 1'b1; w_req_write = wr[i]; w_req_addr = ad[i]; w_req_wdata = wd[i];
      w_req_size = sz[i]; w_req_unsigned = un[i];
      @(posedge clk); #1;
      w_req_valid = 1'b0;
      n_checks++; if ({w_psel, w_penable, w_pwrite, w_pstrb, w_paddr} !== {2'b10, wr[i], xs[i], ad[i] & 32'hFFFFFFF8}) $display("FAIL w_setup[%0d] got %b%b%b %h %h want %b %h %h", i, w_psel, w_penable, w_pwrite, w_pstrb, w_paddr, wr[i], xs[i], ad[i] & 32'hFFFFFFF8); else n_pass++;
      if (wr[i]) begin
        n_checks++; if (w_pwdata !== xw[i]) $display("FAIL w_pwdata[%0d] got %h want %h", i, w_pwdata, xw[i]); else n_pass++;
      end
      cyc = 0;
      while (w_rsp_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      pop_exp(e);
      n_checks++; if (w_rsp_valid !== 1'b1 || {w_rsp_err, w_rsp_rdata} !== {e.err, e.rdata}) $display("FAIL w_rsp[%0d] got v=%b %b/%h want %b/%h", i, w_rsp_valid, w_rsp_err, w_rsp_rdata, e.err, e.rdata); else n_pass++;
      w_rsp_ready = 1'b1;
      @(posedge clk); #1;
      w_rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rts_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
    w_req_valid = 1'b0; w_req_write = 1'b0; w_req_addr = 32'h0; w_req_wdata = 64'h0;
    w_req_size = 2'b00; w_req_unsigned = 1'b0; w_rsp_ready = 1'b0;
    w_pready = 1'b1; w_pslverr = 1'b0; w_prdata = 64'h8765432112345678;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rts_n = 1'b1;
    @(posedge clk); #1;
    test_store_word();
    test_load_ext();
    test_misaligned();
    test_wait_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_dw64();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
